// File: rtl/pet_mood_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pet_pkg
//  Brief    : Mood codes and need-channel indices shared by the pet mood
//             evaluator, its need-flag stage and its bus interface users.
//  Revision : 1.0  initial release
// ============================================================================
package pet_pkg;

    typedef logic [3:0] mood_t;

    localparam mood_t BIEN       = 4'd0;
    localparam mood_t EXCELENTE  = 4'd1;
    localparam mood_t CANSADO    = 4'd2;
    localparam mood_t DORMIDO    = 4'd3;
    localparam mood_t HAMBRIENTO = 4'd4;
    localparam mood_t ENFERMO    = 4'd5;
    localparam mood_t ABURRIDO   = 4'd6;
    localparam mood_t SUCIO      = 4'd7;
    localparam mood_t DESOLADO   = 4'd8;
    localparam mood_t DEPRESION  = 4'd9;
    localparam mood_t MUERTE     = 4'd10;

    localparam int CH_SALUD           = 0;
    localparam int CH_ALIMENTACION    = 1;
    localparam int CH_ENERGIA         = 2;
    localparam int CH_ENTRETENIMIENTO = 3;
    localparam int CH_HIGIENE         = 4;

endpackage
`default_nettype wire

// File: rtl/pet_mood_eval_if.sv
`default_nettype none
// ============================================================================
//  Module   : pet_mood_eval_if
//  Brief    : Need-level / mood bus between the need counters (master) and
//             the mood evaluator (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface pet_mood_eval_if #(
    parameter int N_NEEDS = 5,
    parameter int LVL_W   = 3
);
    logic [N_NEEDS*LVL_W-1:0] levels;
    logic                     dormido;
    logic                     tick;
    logic [3:0]               estado;
    logic                     estado_chg;
    logic                     muerto;

    modport master (
        output levels, dormido, tick,
        input  estado, estado_chg, muerto
    );

    modport slave (
        input  levels, dormido, tick,
        output estado, estado_chg, muerto
    );
endinterface
`default_nettype wire

// File: rtl/pet_mood_eval_need_flags.sv
`default_nettype none
// ============================================================================
//  Module   : pet_need_flags
//  Brief    : Stage 1 of the mood evaluator. Per-channel "low" flags with
//             hysteresis plus registered dying / critical / low counts and
//             the all-channels-full indication.
//  Revision : 1.0  initial release
// ============================================================================
module pet_need_flags
    import pet_pkg::*;
#(
    parameter int N_NEEDS = 5,
    parameter int LVL_W   = 3,
    parameter int LVL_MAX = 7,
    parameter int TH_LOW  = 5,
    parameter int HYST    = 1,
    parameter int TH_CRIT = 3,
    parameter int TH_DEAD = 2,
    parameter int CNT_W   = 3
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic [N_NEEDS*LVL_W-1:0] i_levels,
    output logic      [N_NEEDS-1:0]       o_low,
    output logic      [CNT_W-1:0]         o_dying_cnt,
    output logic      [CNT_W-1:0]         o_crit_cnt,
    output logic      [CNT_W-1:0]         o_low_cnt,
    output logic                          o_all_max
);

    logic [N_NEEDS-1:0] r_low;
    logic [CNT_W-1:0]   r_dying_cnt;
    logic [CNT_W-1:0]   r_crit_cnt;
    logic [CNT_W-1:0]   r_low_cnt;
    logic               r_all_max;

    logic [N_NEEDS-1:0] w_low_nxt;
    logic [CNT_W-1:0]   w_dying;
    logic [CNT_W-1:0]   w_crit;
    logic [CNT_W-1:0]   w_lowc;
    logic               w_all;

    // Next low flags (level between the two thresholds keeps the old flag) and the counts.
    always_comb begin
        int lvl;
        lvl       = 0;
        w_low_nxt = r_low;
        w_dying   = '0;
        w_crit    = '0;
        w_lowc    = '0;
        w_all     = 1'b1;
        for (int i = 0; i < N_NEEDS; i++) begin
            lvl = int'(i_levels[i*LVL_W +: LVL_W]);
            if (lvl < TH_LOW) begin
                w_low_nxt[i] = 1'b1;
            end else if (lvl >= TH_LOW + HYST) begin
                w_low_nxt[i] = 1'b0;
            end
            if (lvl < TH_DEAD) w_dying = w_dying + CNT_W'(1);
            if (lvl < TH_CRIT) w_crit  = w_crit + CNT_W'(1);
            if (lvl != LVL_MAX) w_all  = 1'b0;
        end
        // The low count follows the freshly updated flags so both land in the same cycle.
        for (int i = 0; i < N_NEEDS; i++) begin
            w_lowc = w_lowc + CNT_W'(w_low_nxt[i]);
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_low       <= '0;
            r_dying_cnt <= '0;
            r_crit_cnt  <= '0;
            r_low_cnt   <= '0;
            r_all_max   <= 1'b0;
        end else begin
            r_low       <= w_low_nxt;
            r_dying_cnt <= w_dying;
            r_crit_cnt  <= w_crit;
            r_low_cnt   <= w_lowc;
            r_all_max   <= w_all;
        end
    end

    assign o_low       = r_low;
    assign o_dying_cnt = r_dying_cnt;
    assign o_crit_cnt  = r_crit_cnt;
    assign o_low_cnt   = r_low_cnt;
    assign o_all_max   = r_all_max;

endmodule
`default_nettype wire

// File: rtl/pet_mood_eval.sv
`default_nettype none
// ============================================================================
//  Module   : pet_mood_eval
//  Brief    : Pet mood evaluator. Need flags (stage 1), priority-encoded mood
//             candidate (stage 2), tick-debounced commit with sticky death
//             latch (stage 3).
//  Revision : 1.0  initial release
// ============================================================================
module pet_mood_eval
    import pet_pkg::*;
#(
    parameter int N_NEEDS = 5,
    parameter int LVL_W   = 3,
    parameter int LVL_MAX = 7,
    parameter int TH_LOW  = 5,
    parameter int HYST    = 1,
    parameter int TH_CRIT = 3,
    parameter int TH_DEAD = 2,
    parameter int N_DEAD  = 4,
    parameter int N_DESOL = 3,
    parameter int N_DEPR  = 2,
    parameter int HOLD    = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    pet_mood_eval_if.slave bus
);

    localparam int CNT_W = $clog2(N_NEEDS + 1);

    logic [N_NEEDS-1:0] w_low;
    logic [CNT_W-1:0]   w_dying;
    logic [CNT_W-1:0]   w_crit;
    logic [CNT_W-1:0]   w_lowc;
    logic               w_all_max;

    logic               r_dorm_d;
    mood_t              r_cand;
    mood_t              r_cand_prev;
    mood_t              w_cand_nxt;

    mood_t              r_estado;
    logic [3:0]         r_cnt;
    logic               r_chg;
    logic               r_muerto;
    mood_t              w_estado_nxt;
    logic [3:0]         w_cnt_nxt;
    logic [3:0]         w_cnt_inc;
    logic               w_chg_nxt;
    logic               w_muerto_nxt;

    pet_need_flags #(
        .N_NEEDS (N_NEEDS),
        .LVL_W   (LVL_W),
        .LVL_MAX (LVL_MAX),
        .TH_LOW  (TH_LOW),
        .HYST    (HYST),
        .TH_CRIT (TH_CRIT),
        .TH_DEAD (TH_DEAD),
        .CNT_W   (CNT_W)
    ) u_flags (
        .clk         (clk),
        .rst         (rst),
        .i_levels    (bus.levels),
        .o_low       (w_low),
        .o_dying_cnt (w_dying),
        .o_crit_cnt  (w_crit),
        .o_low_cnt   (w_lowc),
        .o_all_max   (w_all_max)
    );

    // Stage 2 priority encoder: first matching rule wins.
    always_comb begin
        w_cand_nxt = BIEN;
        if (r_dorm_d)                           w_cand_nxt = DORMIDO;
        else if (int'(w_dying) >= N_DEAD)       w_cand_nxt = MUERTE;
        else if (int'(w_crit) >= N_DESOL)       w_cand_nxt = DESOLADO;
        else if (int'(w_lowc) >= N_DEPR)        w_cand_nxt = DEPRESION;
        else if (w_low[CH_ALIMENTACION])        w_cand_nxt = HAMBRIENTO;
        else if (w_low[CH_SALUD])               w_cand_nxt = ENFERMO;
        else if (w_low[CH_HIGIENE])             w_cand_nxt = SUCIO;
        else if (w_low[CH_ENTRETENIMIENTO])     w_cand_nxt = ABURRIDO;
        else if (w_low[CH_ENERGIA])             w_cand_nxt = CANSADO;
        else if (w_all_max)                     w_cand_nxt = EXCELENTE;
    end

    // Stage 2 register; dormido is delayed one clk so it lines up with the stage 1 counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dorm_d    <= 1'b0;
            r_cand      <= BIEN;
            r_cand_prev <= BIEN;
        end else begin
            r_dorm_d    <= bus.dormido;
            r_cand      <= w_cand_nxt;
            r_cand_prev <= r_cand;
        end
    end

    // Stage 3 commit decision: urgent moods commit at once, others need HOLD ticks.
    always_comb begin
        w_estado_nxt = r_estado;
        w_cnt_nxt    = r_cnt;
        w_chg_nxt    = 1'b0;
        w_muerto_nxt = r_muerto;
        // A fresh candidate restarts the count; a tick in that same cycle is its first tick.
        w_cnt_inc    = ((r_cand != r_cand_prev) ? 4'd0 : r_cnt) + {3'b000, bus.tick};
        if (!r_muerto) begin
            if (r_cand == r_estado) begin
                w_cnt_nxt = 4'd0;
            end else if (r_cand == MUERTE || r_cand == DORMIDO) begin
                w_estado_nxt = r_cand;
                w_chg_nxt    = 1'b1;
                w_cnt_nxt    = 4'd0;
                w_muerto_nxt = (r_cand == MUERTE);
            end else if (int'(w_cnt_inc) >= HOLD) begin
                w_estado_nxt = r_cand;
                w_chg_nxt    = 1'b1;
                w_cnt_nxt    = 4'd0;
            end else begin
                w_cnt_nxt = w_cnt_inc;
            end
        end
    end

    // Stage 3 register: committed mood, change pulse and death latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= BIEN;
            r_cnt    <= 4'd0;
            r_chg    <= 1'b0;
            r_muerto <= 1'b0;
        end else begin
            r_estado <= w_estado_nxt;
            r_cnt    <= w_cnt_nxt;
            r_chg    <= w_chg_nxt;
            r_muerto <= w_muerto_nxt;
        end
    end

    assign bus.estado     = r_estado;
    assign bus.estado_chg = r_chg;
    assign bus.muerto     = r_muerto;

endmodule
`default_nettype wire
